// File: rtl/stream_demux_pkg.sv
// Shared types for the packet-aware stream demultiplexer.
package stream_demux_pkg;

  typedef enum logic {
    ROUTE_IDLE,
    ROUTE_LOCKED
  } route_state_t;

endpackage

// File: rtl/stream_skid_buffer.sv
// Generic 2-entry valid/ready register slice: registered outputs, registered in_ready,
// full throughput with no combinational path from out_ready to in_ready.
module stream_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] head_reg, head_next;
  logic [WIDTH-1:0] skid_reg, skid_next;
  logic             head_valid_reg, head_valid_next;
  logic             skid_valid_reg, skid_valid_next;
  logic             in_ready_reg;
  logic             in_accept;
  logic             head_load;

  assign in_accept = in_valid && in_ready_reg;
  // Head may take a new beat when it is empty or being drained this cycle.
  assign head_load = !head_valid_reg || out_ready;

  always_comb begin
    head_next       = head_reg;
    head_valid_next = head_valid_reg;
    skid_next       = skid_reg;
    skid_valid_next = skid_valid_reg;
    if (head_load) begin
      if (skid_valid_reg) begin
        head_next       = skid_reg;
        head_valid_next = 1'b1;
        skid_valid_next = 1'b0;
      end else begin
        head_valid_next = in_accept;
        if (in_accept) begin
          head_next = in_data;
        end
      end
    end else if (in_accept) begin
      skid_next       = in_data;
      skid_valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg       <= '0;
      skid_reg       <= '0;
      head_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
      in_ready_reg   <= 1'b0;
    end else begin
      head_reg       <= head_next;
      skid_reg       <= skid_next;
      head_valid_reg <= head_valid_next;
      skid_valid_reg <= skid_valid_next;
      in_ready_reg   <= !skid_valid_next;
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_data  = head_reg;
  assign out_valid = head_valid_reg;

endmodule

// File: rtl/stream_demux.sv
// Packet-aware demultiplexer: route latched on the first beat of a packet, held to the
// last beat, and carried with each beat through a 2-entry skid buffer.
module stream_demux #(
  parameter int DATA_SIZE   = 8,
  parameter int SELECT_SIZE = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_SIZE-1:0]      in_data,
  input  logic [SELECT_SIZE-1:0]    in_port,
  input  logic                      in_last,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [DATA_SIZE-1:0]      out_data,
  output logic                      out_last,
  output logic [2**SELECT_SIZE-1:0] out_valid,
  input  logic [2**SELECT_SIZE-1:0] out_ready
);

  import stream_demux_pkg::*;

  localparam int PORTS = 2**SELECT_SIZE;
  localparam int WIDTH = DATA_SIZE + 1 + SELECT_SIZE;

  route_state_t           state_reg, state_next;
  logic [SELECT_SIZE-1:0] route_reg, route_next;
  logic [SELECT_SIZE-1:0] beat_port;
  logic [SELECT_SIZE-1:0] head_port;
  logic [WIDTH-1:0]       head_bus;
  logic                   head_valid;
  logic                   head_ready;
  logic                   in_accept;

  assign in_accept = in_valid && in_ready;
  // in_port is only meaningful on the first beat; later beats reuse the latched route.
  assign beat_port = (state_reg == ROUTE_IDLE) ? in_port : route_reg;

  always_comb begin
    state_next = state_reg;
    route_next = route_reg;
    if (in_accept) begin
      route_next = beat_port;
      state_next = in_last ? ROUTE_IDLE : ROUTE_LOCKED;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ROUTE_IDLE;
      route_reg <= '0;
    end else begin
      state_reg <= state_next;
      route_reg <= route_next;
    end
  end

  stream_skid_buffer #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   ({in_data, in_last, beat_port}),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (head_bus),
    .out_valid (head_valid),
    .out_ready (head_ready)
  );

  assign {out_data, out_last, head_port} = head_bus;
  assign head_ready = out_ready[head_port];

  genvar gi;
  generate
    for (gi = 0; gi < PORTS; gi++) begin : g_valid
      localparam logic [SELECT_SIZE-1:0] PORT_ID = SELECT_SIZE'(gi);
      assign out_valid[gi] = head_valid && (head_port == PORT_ID);
    end
  endgenerate

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux: outputs sampled on the falling edge, inputs driven there too.
module tb_stream_demux;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = '0;
  logic [1:0] in_port = '0;
  logic       in_last = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic [3:0] out_valid;
  logic [3:0] out_ready = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  stream_demux #(
    .DATA_SIZE   (8),
    .SELECT_SIZE (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_port   (in_port),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end else begin
      $display("ok   %s: %0h", tag, observed);
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic [1:0] p, input logic l);
    in_data  = d;
    in_port  = p;
    in_last  = l;
    in_valid = 1'b1;
  endtask

  task automatic expect_beat(input string tag, input logic [3:0] v, input logic [7:0] d, input logic l);
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    check({tag, ".data"}, 32'(out_data), 32'(d));
    check({tag, ".last"}, 32'(out_last), 32'(l));
  endtask

  initial begin
    // Reset held
    repeat (2) @(negedge clk);
    check("rst.valid", 32'(out_valid), 32'h0);
    check("rst.ready", 32'(in_ready), 32'h0);
    check("rst.data", 32'(out_data), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst.ready_rise", 32'(in_ready), 32'h1);

    // Single-beat packet
    out_ready = 4'hF;
    drive(8'hA5, 2'd2, 1'b1);
    @(negedge clk);
    expect_beat("single", 4'b0100, 8'hA5, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    check("single.drain", 32'(out_valid), 32'h0);

    // Route lock: in_port on beats 2 and 3 must be ignored
    drive(8'h01, 2'd1, 1'b0);
    @(negedge clk);
    expect_beat("lock.b1", 4'b0010, 8'h01, 1'b0);
    drive(8'h02, 2'd3, 1'b0);
    @(negedge clk);
    expect_beat("lock.b2", 4'b0010, 8'h02, 1'b0);
    drive(8'h03, 2'd0, 1'b1);
    @(negedge clk);
    expect_beat("lock.b3", 4'b0010, 8'h03, 1'b1);
    drive(8'h04, 2'd3, 1'b1);
    @(negedge clk);
    expect_beat("lock.next", 4'b1000, 8'h04, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    check("lock.drain", 32'(out_valid), 32'h0);

    // Backpressure on port 3; other ports ready but must be ignored
    out_ready = 4'b0111;
    drive(8'h10, 2'd3, 1'b0);
    @(negedge clk);
    expect_beat("bp.head", 4'b1000, 8'h10, 1'b0);
    check("bp.ready1", 32'(in_ready), 32'h1);
    drive(8'h11, 2'd3, 1'b0);
    @(negedge clk);
    expect_beat("bp.stall1", 4'b1000, 8'h10, 1'b0);
    check("bp.ready0", 32'(in_ready), 32'h0);
    drive(8'h12, 2'd3, 1'b0);
    @(negedge clk);
    expect_beat("bp.stall2", 4'b1000, 8'h10, 1'b0);
    check("bp.ready0b", 32'(in_ready), 32'h0);
    out_ready = 4'hF;
    @(negedge clk);
    expect_beat("bp.out2", 4'b1000, 8'h11, 1'b0);
    check("bp.ready_back", 32'(in_ready), 32'h1);
    @(negedge clk);
    expect_beat("bp.out3", 4'b1000, 8'h12, 1'b0);
    drive(8'h13, 2'd3, 1'b1);
    @(negedge clk);
    expect_beat("bp.out4", 4'b1000, 8'h13, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    check("bp.drain", 32'(out_valid), 32'h0);

    // Throughput: 16 back-to-back beats to port 0
    for (int i = 0; i <= 16; i++) begin
      if (i > 0) begin
        expect_beat($sformatf("tput.%0d", i - 1), 4'b0001, 8'(8'h20 + i - 1), (i == 16));
      end
      check($sformatf("tput.ready%0d", i), 32'(in_ready), 32'h1);
      if (i < 16) begin
        drive(8'(8'h20 + i), 2'd0, (i == 15));
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    check("tput.drain", 32'(out_valid), 32'h0);

    // Mid-packet reset
    drive(8'h30, 2'd1, 1'b0);
    @(negedge clk);
    drive(8'h31, 2'd1, 1'b0);
    @(negedge clk);
    expect_beat("mrst.pre", 4'b0010, 8'h31, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mrst.valid", 32'(out_valid), 32'h0);
    check("mrst.ready", 32'(in_ready), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst.ready_rise", 32'(in_ready), 32'h1);
    drive(8'h40, 2'd2, 1'b1);
    @(negedge clk);
    expect_beat("mrst.new", 4'b0100, 8'h40, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    check("mrst.drain", 32'(out_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
